ntt_mdc_sequencer: RTL and testbench
====================================

// Module: ntt_mdc_sequencer
// PURPOSE
//  Job-level controller for the MDC NTT pipeline (chain of LOGN-1 butterfly stages + twiddle ROMs).
//  Accepts one transform command at a time and latches the mode (fntt/intt, CT/GS butterfly) and modulus.
//  Clears the stage counters, then streams N/2 coefficient pairs from the input buffer into stage 0.
//  Collects N/2 result pairs from the last stage into the output buffer and reports done or timeout.
// PARAMETERS
//  LOGN        10    log2 of transform size N; N/2 pairs per job.
//  LOGQ        64    coefficient/modulus width.
//  DELAY_BRAM  2     input-buffer read latency, in cycles, from rd_en to valid data.
//  CLR_CYCLES  2     length of the pipe_rst pulse; must be >= 2 so the stages' registered mode bits settle.
//  TIMEOUT     4096  maximum DRAIN cycles before the job aborts.
// PORTS
//  clk           in   1        clock
//  rst           in   1        synchronous active-high reset
//  cmd_valid     in   1        command request
//  cmd_ready     out  1        command accepted when valid&ready
//  cmd_intt      in   1        1 = inverse NTT
//  cmd_btf_gs    in   1        1 = Gentleman-Sande butterfly, 0 = Cooley-Tukey butterfly
//  cmd_q         in   LOGQ     modulus for this job
//  intt          out  1        latched mode to all stages; held for the whole job
//  btf_gs        out  1        latched butterfly type; held for the whole job
//  q             out  LOGQ     latched modulus; held for the whole job
//  pipe_rst      out  1        stage counter clear (drives stage rst)
//  rd_en         out  1        input buffer read enable
//  rd_addr       out  LOGN-1   input buffer pair address
//  pipe_start    out  1        data-valid strobe to stage 0 (drives stage start)
//  pipe_finish   in   1        data-valid strobe from the last stage (its finish output)
//  wr_en         out  1        output buffer write enable
//  wr_addr       out  LOGN-1   output buffer pair address
//  busy          out  1        job in progress
//  done          out  1        1-cycle pulse at job end
//  err           out  1        timeout flag; sticky until the next accepted command
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except cmd_ready=1; counters cleared. Reset mid-job aborts the job with no done pulse.
//  FSM states: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
//  IDLE:  cmd_ready=1.
//    - On valid&ready: latch intt, btf_gs and q; clear err; go to CLEAR.
//    - cmd_ready is 0 in every other state; a cmd_valid outside IDLE is ignored and the job continues.
//  CLEAR: pipe_rst=1 for CLR_CYCLES cycles; go to FEED.
//  FEED:  rd_en=1 for exactly N/2 consecutive cycles; rd_addr=0..N/2-1.
//    - pipe_start = rd_en delayed by DELAY_BRAM cycles (shift register), so it lines up with the read data.
//    - After the last read, go to DRAIN. The delay line keeps issuing the trailing pipe_start pulses.
//  Collection (FEED and DRAIN):
//    - wr_en = pipe_finish while wr_cnt < N/2; wr_addr = wr_cnt; wr_cnt increments on each write.
//    - pipe_finish may arrive during FEED. Any pipe_finish after the N/2-th write is ignored.
//  DRAIN: leave when wr_cnt == N/2, or when the drain cycle counter reaches TIMEOUT (then err=1). Go to DONE.
//  DONE:  done=1 for one cycle; go to IDLE. The latched mode outputs keep their values until the next command.
//  busy=1 in CLEAR, FEED, DRAIN and DONE.
//  Counters are LOGN-1 bits for addresses, plus a carry bit for the N/2 terminal count; no wrap within a job.
//  Minimum job latency: CLR_CYCLES + N/2 + DELAY_BRAM + pipeline latency + 1 cycles.
// TESTING  (LOGN=4, N/2=8, DELAY_BRAM=2, CLR_CYCLES=2)
//  1. Fntt job, cmd_q=0x3001, last-stage model with 20-cycle latency.
//     -> pipe_rst high 2 cycles; rd_addr 0..7; pipe_start trails rd_en by 2 cycles.
//     -> wr_addr 0..7; one done pulse; err=0; q=0x3001 throughout.
//  2. Intt with btf_gs=1 -> intt=1 and btf_gs=1 stable from the cycle after acceptance until the next command.
//  3. cmd_valid held high during a job -> cmd_ready stays 0 and exactly one job runs; the next command is accepted in IDLE after done.
//  4. pipe_finish never asserted -> done pulse after TIMEOUT drain cycles with err=1; err clears when the next command is accepted.
//  5. rst asserted mid-FEED (rd_addr=3) -> next cycle IDLE, rd_en=0, busy=0, no done; a new job restarts from rd_addr=0.
//  6. 12 pipe_finish pulses (extra) -> exactly 8 writes (wr_addr 0..7); the extra pulses produce no wr_en.

Source files
------------

// File: rtl/ntt_mdc_sequencer.sv
// ntt_mdc_sequencer: job-level controller for the MDC NTT pipeline.
// Latches the job mode, clears the stages, streams pairs in and collects results.
module ntt_mdc_sequencer #(
  parameter int LOGN       = 10,
  parameter int LOGQ       = 64,
  parameter int DELAY_BRAM = 2,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_intt,
  input  logic            cmd_btf_gs,
  input  logic [LOGQ-1:0] cmd_q,
  output logic            intt,
  output logic            btf_gs,
  output logic [LOGQ-1:0] q,
  output logic            pipe_rst,
  output logic            rd_en,
  output logic [LOGN-2:0] rd_addr,
  output logic            pipe_start,
  input  logic            pipe_finish,
  output logic            wr_en,
  output logic [LOGN-2:0] wr_addr,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int AW = LOGN - 1;
  localparam int CW = $clog2(CLR_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = DELAY_BRAM;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   clr_q, clr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     wr_q, wr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic            intt_q, intt_d;
  logic            gs_q, gs_d;
  logic [LOGQ-1:0] q_q, q_d;
  logic            err_q, err_d;

  assign rd_addr    = rd_q;
  assign wr_addr    = wr_q[AW-1:0];
  assign pipe_start = dly_q[DW-1];
  assign intt       = intt_q;
  assign btf_gs     = gs_q;
  assign q          = q_q;
  assign err        = err_q;

  // Next-state, counters and strobes; wr_q's top bit marks all pairs written.
  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    tmo_d     = tmo_q;
    intt_d    = intt_q;
    gs_d      = gs_q;
    q_d       = q_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    pipe_rst  = 1'b0;
    rd_en     = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    wr_en     = pipe_finish && !wr_q[AW] &&
                (state_q == S_FEED || state_q == S_DRAIN);
    if (wr_en) wr_d = wr_q + (AW+1)'(1);
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          intt_d  = cmd_intt;
          gs_d    = cmd_btf_gs;
          q_d     = cmd_q;
          err_d   = 1'b0;
          clr_d   = '0;
          rd_d    = '0;
          wr_d    = '0;
          tmo_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        pipe_rst = 1'b1;
        clr_d    = clr_q + CW'(1);
        if (clr_q == CLR_LAST) state_d = S_FEED;
      end
      S_FEED: begin
        rd_en = 1'b1;
        rd_d  = rd_q + AW'(1);
        if (rd_q == '1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        tmo_d = tmo_q + TW'(1);
        if (wr_q[AW]) begin
          state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    dly_d = (dly_q << 1) | DW'(rd_en);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      clr_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      tmo_q   <= '0;
      dly_q   <= '0;
      intt_q  <= 1'b0;
      gs_q    <= 1'b0;
      q_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      tmo_q   <= tmo_d;
      dly_q   <= dly_d;
      intt_q  <= intt_d;
      gs_q    <= gs_d;
      q_q     <= q_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ntt_mdc_sequencer.sv
// tb_ntt_mdc_sequencer: scoreboard bench for the NTT job sequencer.
// Last-stage model echoes pipe_start after a programmable latency.
module tb_ntt_mdc_sequencer;

  localparam int LOGN = 4;
  localparam int LOGQ = 64;
  localparam int HALF = 8;
  localparam int TMO  = 64;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_intt;
  logic            cmd_btf_gs;
  logic [LOGQ-1:0] cmd_q;
  logic            intt;
  logic            btf_gs;
  logic [LOGQ-1:0] q;
  logic            pipe_rst;
  logic            rd_en;
  logic [LOGN-2:0] rd_addr;
  logic            pipe_start;
  logic            pipe_finish;
  logic            wr_en;
  logic [LOGN-2:0] wr_addr;
  logic            busy;
  logic            done;
  logic            err;

  ntt_mdc_sequencer #(
    .LOGN(LOGN), .LOGQ(LOGQ), .DELAY_BRAM(2),
    .CLR_CYCLES(2), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_intt(cmd_intt), .cmd_btf_gs(cmd_btf_gs), .cmd_q(cmd_q),
    .intt(intt), .btf_gs(btf_gs), .q(q),
    .pipe_rst(pipe_rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .pipe_start(pipe_start), .pipe_finish(pipe_finish),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int rdq[$];
  int wrq[$];
  bit dq[$];

  bit            cur_intt = 0;
  bit            cur_gs   = 0;
  logic [63:0]   cur_q    = '0;
  bit            mon_on   = 0;
  int            fin_mode = 1;
  int            lat      = 20;
  int            echo_left = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Last-stage model: finish = start delayed by lat, plus optional echoes.
  initial begin
    bit [63:0] sr;
    bit rs;
    bit echo;
    sr = '0;
    pipe_finish = 0;
    forever begin
      @(posedge clk);
      rs = rst;
      #1;
      if (rs || pipe_rst) sr = '0;
      else sr = {sr[62:0], pipe_start};
      echo = (fin_mode == 2) && (echo_left > 0) && sr[lat+8];
      if (echo) echo_left--;
      pipe_finish = ((fin_mode != 0) && sr[lat]) || echo;
    end
  end

  // Monitor: pops scoreboard entries whenever the DUT presents an event.
  initial begin
    bit h1, h2, prev_rd;
    int clr_run;
    h1 = 0; h2 = 0; prev_rd = 0; clr_run = 0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("cmd_ready_vs_busy", cmd_ready, !busy);
        chk("intt_hold", intt, cur_intt);
        chk("btf_gs_hold", btf_gs, cur_gs);
        chk("q_hold", q, cur_q);
        chk("start_trails_rd", pipe_start, h2);
        if (rd_en) begin
          if (rdq.size() == 0) chk("rd_extra", rd_en, 0);
          else chk("rd_addr", rd_addr, rdq.pop_front());
        end
        if (prev_rd && !rd_en) chk("rd_burst_left", rdq.size(), 0);
        if (wr_en) begin
          if (wrq.size() == 0) chk("wr_extra", wr_en, 0);
          else chk("wr_addr", wr_addr, wrq.pop_front());
        end
        if (done) begin
          if (dq.size() == 0) chk("done_extra", done, 0);
          else chk("done_err", err, dq.pop_front());
        end
        if (pipe_rst) clr_run++;
        else if (clr_run != 0) begin
          chk("clr_len", clr_run, 2);
          chk("feed_after_clr", rd_en, 1);
          clr_run = 0;
        end
        h2 = h1;
        h1 = rd_en;
        prev_rd = rd_en;
        if (rst) begin
          h1 = 0; h2 = 0; clr_run = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit i, input bit g, input logic [63:0] qq,
                      input bit hold);
    int n;
    cmd_intt = i;
    cmd_btf_gs = g;
    cmd_q = qq;
    cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 500) begin
      tick();
      n++;
    end
    chk("cmd_accept", cmd_ready, 1);
    for (int k = 0; k < HALF; k++) begin
      rdq.push_back(k);
      if (fin_mode != 0) wrq.push_back(k);
    end
    dq.push_back(fin_mode == 0);
    tick();
    cur_intt = i;
    cur_gs = g;
    cur_q = qq;
    if (!hold) cmd_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 500) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int n;
    int cnt;
    rst = 1;
    cmd_valid = 0;
    cmd_intt = 0;
    cmd_btf_gs = 0;
    cmd_q = '0;
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_pipe_rst", pipe_rst, 0);
    chk("rst_pipe_start", pipe_start, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_mode", {intt, btf_gs}, 0);
    chk("rst_q", q, 0);
    rst = 0;
    mon_on = 1;
    tick();

    fin_mode = 1;
    lat = 20;
    send(0, 0, 64'h3001, 0);
    wait_done();
    repeat (3) tick();

    send(1, 1, {$urandom(), $urandom()}, 0);
    wait_done();
    repeat (5) tick();

    send(0, 1, 64'h1234_5678, 1);
    repeat (6) tick();
    cmd_q = 64'hdead_beef;
    cmd_intt = 1;
    wait_done();
    send(1, 0, 64'hdead_beef, 0);
    wait_done();
    repeat (3) tick();

    fin_mode = 0;
    send(0, 1, 64'h7681, 0);
    n = 0;
    cnt = 0;
    while (!done && n < 500) begin
      if (busy && !pipe_rst && !rd_en) cnt++;
      tick();
      n++;
    end
    chk("tmo_done_seen", done, 1);
    chk("drain_cycles", cnt, TMO);
    repeat (4) tick();
    chk("err_sticky", err, 1);
    fin_mode = 1;
    send(1, 1, 64'h3001, 0);
    chk("err_cleared", err, 0);
    wait_done();
    repeat (3) tick();

    send(0, 0, 64'h5555, 0);
    n = 0;
    while (!(rd_en && rd_addr == 3) && n < 100) begin
      tick();
      n++;
    end
    chk("rd3_reached", rd_en, 1);
    rst = 1;
    tick();
    rst = 0;
    rdq.delete();
    wrq.delete();
    dq.delete();
    cur_intt = 0;
    cur_gs = 0;
    cur_q = '0;
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    repeat (30) tick();
    send(1, 0, 64'h6001, 0);
    wait_done();
    repeat (3) tick();

    fin_mode = 2;
    echo_left = 4;
    send(0, 1, 64'hf001, 0);
    wait_done();
    repeat (20) tick();
    fin_mode = 1;

    for (int j = 0; j < 8; j++) begin
      lat = $urandom_range(1, 30);
      send($urandom_range(0, 1), $urandom_range(0, 1),
           {$urandom(), $urandom()}, 0);
      wait_done();
      repeat ($urandom_range(0, 5)) tick();
    end

    repeat (40) tick();
    chk("rd_queue_empty", rdq.size(), 0);
    chk("wr_queue_empty", wrq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
